// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Holds the scan states, the digit-store entry and the anode/segment idle patterns.
package display_scan_ctrl_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
        logic       dp;
    } digit_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low one-hot anode pattern for a scan index.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Key-entry inputs and display outputs of the scan controller.
// master = keypad/host side, slave = display controller.
interface display_scan_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_dp;
    logic       clear;
    logic       lz_blank;
    logic [3:0] an;
    logic [7:0] sieteseg_a2g_dp;

    modport master (
        output key_valid, key_code, key_dp, clear, lz_blank,
        input  an, sieteseg_a2g_dp
    );

    modport slave (
        input  key_valid, key_code, key_dp, clear, lz_blank,
        output an, sieteseg_a2g_dp
    );
endinterface

// File: rtl/display_scan_ctrl_hex2seg.sv
// Hex nibble to 7-segment pattern, active-low, bit 6 = segment a ... bit 0 = segment g.
// Lower-case b and d keep them distinguishable from 8 and 0.
module display_scan_ctrl_hex2seg (
    input  logic [3:0] hex,
    output logic [6:0] seg_a2g
);
    always_comb begin
        seg_a2g = 7'b1111111;
        case (hex)
            4'h0: seg_a2g = 7'b0000001;
            4'h1: seg_a2g = 7'b1001111;
            4'h2: seg_a2g = 7'b0010010;
            4'h3: seg_a2g = 7'b0000110;
            4'h4: seg_a2g = 7'b1001100;
            4'h5: seg_a2g = 7'b0100100;
            4'h6: seg_a2g = 7'b0100000;
            4'h7: seg_a2g = 7'b0001111;
            4'h8: seg_a2g = 7'b0000000;
            4'h9: seg_a2g = 7'b0000100;
            4'hA: seg_a2g = 7'b0001000;
            4'hB: seg_a2g = 7'b1100000;
            4'hC: seg_a2g = 7'b0110001;
            4'hD: seg_a2g = 7'b1000010;
            4'hE: seg_a2g = 7'b0110000;
            4'hF: seg_a2g = 7'b0111000;
            default: seg_a2g = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit shift-in display store with a guarded, time-multiplexed anode scan.
// Segment data is latched at the start of each slot so it never changes while a digit is lit.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int DRIVE_CYC = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave dsp
);
    localparam int MAX_CYC = (DRIVE_CYC > GUARD_CYC) ? DRIVE_CYC : GUARD_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(N_DIG);

    localparam logic [CW-1:0]    DRIVE_LAST = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0]    GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

    digit_t            store_reg  [N_DIG];
    digit_t            store_next [N_DIG];
    logic [N_DIG-1:0]  nz;
    logic [N_DIG-1:0]  lz_mask;

    scan_state_t       state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  sel_idx;
    logic [CW-1:0]     cnt_reg;
    logic [3:0]        an_reg;
    logic [7:0]        seg_reg;
    logic [7:0]        seg_next;
    digit_t            sel_entry;
    logic [6:0]        seg7;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_digit
            if (gi == 0) begin : g_load
                assign store_next[gi] = {1'b1, dsp.key_code, dsp.key_dp};
                assign lz_mask[gi]    = 1'b0;
            end else begin : g_shift
                assign store_next[gi] = store_reg[gi-1];
                // A zero is leading when nothing valid and non-zero sits at or above it.
                assign lz_mask[gi] = dsp.lz_blank && store_reg[gi].valid
                                     && (store_reg[gi].nibble == 4'h0) && !store_reg[gi].dp
                                     && !(|nz[N_DIG-1:gi]);
            end
            assign nz[gi] = store_reg[gi].valid && (store_reg[gi].nibble != 4'h0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N_DIG; i++) begin
            if (!rst_n) begin
                store_reg[i] <= '0;
            end else if (dsp.clear) begin
                store_reg[i] <= '0;
            end else if (dsp.key_valid) begin
                store_reg[i] <= store_next[i];
            end
        end
    end

    // Encode the digit whose slot starts next: the current index while leaving
    // GUARD (only used when GUARD is skipped), the following index while in DRIVE.
    always_comb begin
        idx_next  = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        sel_idx   = (state_reg == GUARD) ? idx_reg : idx_next;
        sel_entry = store_reg[sel_idx];
        if (!sel_entry.valid || lz_mask[sel_idx]) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = {seg7, ~sel_entry.dp};
        end
    end

    display_scan_ctrl_hex2seg u_hex2seg (
        .hex     (sel_entry.nibble),
        .seg_a2g (seg7)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= GUARD;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            an_reg    <= AN_OFF;
            seg_reg   <= SEG_BLANK;
        end else begin
            case (state_reg)
                GUARD: begin
                    if (GUARD_CYC == 0 || cnt_reg == GUARD_LAST) begin
                        state_reg <= DRIVE;
                        cnt_reg   <= '0;
                        an_reg    <= an_select(idx_reg);
                        if (GUARD_CYC == 0) begin
                            seg_reg <= seg_next;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_reg == DRIVE_LAST) begin
                        cnt_reg <= '0;
                        idx_reg <= idx_next;
                        seg_reg <= seg_next;
                        if (GUARD_CYC == 0) begin
                            an_reg <= an_select(idx_next);
                        end else begin
                            state_reg <= GUARD;
                            an_reg    <= AN_OFF;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= GUARD;
                    an_reg    <= AN_OFF;
                end
            endcase
        end
    end

    assign dsp.an              = an_reg;
    assign dsp.sieteseg_a2g_dp = seg_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with short scan timing (DRIVE 4, GUARD 1).
// Expected segment codes are hand-derived from the active-low a..g,dp encoding.
module tb_display_scan_ctrl;
    localparam int DRIVE_CYC = 4;
    localparam int GUARD_CYC = 1;
    localparam int SLOT      = DRIVE_CYC + GUARD_CYC;
    localparam int FRAME     = 4 * SLOT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    display_scan_ctrl_if dsp ();

    display_scan_ctrl #(
        .N_DIG     (4),
        .DRIVE_CYC (DRIVE_CYC),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dsp   (dsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] code, input logic dp);
        dsp.key_code  = code;
        dsp.key_dp    = dp;
        dsp.key_valid = 1'b1;
        tick();
        dsp.key_valid = 1'b0;
        dsp.key_dp    = 1'b0;
        $display("key %h dp %b", code, dp);
    endtask

    task automatic do_clear();
        dsp.clear = 1'b1;
        tick();
        dsp.clear = 1'b0;
        $display("clear");
    endtask

    // Called right after reset release; walks one frame plus the next guard.
    task automatic check_scan(input string tag);
        logic [3:0] pat;
        logic [3:0] exp_an;
        int         f;
        for (int t = 0; t <= FRAME; t++) begin
            if (t > 0) tick();
            f   = t % FRAME;
            pat = 4'b0001 << (f / SLOT);
            exp_an = ((f % SLOT) == 0) ? 4'hF : ~pat;
            check($sformatf("%s_an_t%0d", tag, t), {28'd0, dsp.an}, {28'd0, exp_an});
            check($sformatf("%s_seg_t%0d", tag, t), {24'd0, dsp.sieteseg_a2g_dp}, 32'h0000_00FF);
        end
        $display("scan %s: frame sequence checked", tag);
    endtask

    // exp packs digit3 in [31:24] down to digit0 in [7:0].
    task automatic expect_display(input string tag, input logic [31:0] exp);
        logic [31:0] segs;
        logic [3:0]  seen;
        logic [3:0]  pat;
        logic        stable;
        repeat (2 * FRAME) tick();
        segs   = '1;
        seen   = '0;
        stable = 1'b1;
        for (int t = 0; t < FRAME + SLOT; t++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                pat = 4'b0001 << d;
                if (dsp.an == ~pat) begin
                    if (seen[d] && segs[8*d +: 8] != dsp.sieteseg_a2g_dp) stable = 1'b0;
                    seen[d]         = 1'b1;
                    segs[8*d +: 8]  = dsp.sieteseg_a2g_dp;
                end
            end
        end
        check({tag, "_seen"}, {28'd0, seen}, 32'h0000_000F);
        check({tag, "_stable"}, {31'd0, stable}, 32'd1);
        for (int d = 3; d >= 0; d--) begin
            check($sformatf("%s_d%0d", tag, d), {24'd0, segs[8*d +: 8]}, {24'd0, exp[8*d +: 8]});
        end
        $display("display %s: %h expected %h", tag, segs, exp);
    endtask

    initial begin
        logic found;
        dsp.key_valid = 1'b0;
        dsp.key_code  = 4'h0;
        dsp.key_dp    = 1'b0;
        dsp.clear     = 1'b0;
        dsp.lz_blank  = 1'b0;

        repeat (3) tick();
        check("rst_an", {28'd0, dsp.an}, 32'h0000_000F);
        check("rst_seg", {24'd0, dsp.sieteseg_a2g_dp}, 32'h0000_00FF);
        rst_n = 1'b1;
        check_scan("por");

        press_key(4'h1, 1'b0);
        press_key(4'h2, 1'b0);
        press_key(4'h3, 1'b0);
        press_key(4'h4, 1'b0);
        expect_display("keys1234", 32'h9F25_0D99);

        do_clear();
        dsp.lz_blank = 1'b1;
        press_key(4'h0, 1'b0);
        press_key(4'h0, 1'b0);
        press_key(4'h5, 1'b0);
        expect_display("lz_on", 32'hFFFF_FF49);
        dsp.lz_blank = 1'b0;
        expect_display("lz_off", 32'hFF03_0349);

        do_clear();
        dsp.lz_blank = 1'b1;
        press_key(4'h0, 1'b0);
        expect_display("lz_digit0", 32'hFFFF_FF03);

        do_clear();
        press_key(4'h0, 1'b1);
        press_key(4'h7, 1'b0);
        expect_display("lz_dp", 32'hFFFF_021F);
        dsp.lz_blank = 1'b0;

        do_clear();
        press_key(4'h8, 1'b1);
        expect_display("dp8", 32'hFFFF_FF00);

        dsp.clear     = 1'b1;
        dsp.key_code  = 4'h9;
        dsp.key_valid = 1'b1;
        tick();
        dsp.clear     = 1'b0;
        dsp.key_valid = 1'b0;
        $display("clear with key 9");
        expect_display("clear_wins", 32'hFFFF_FFFF);

        press_key(4'hA, 1'b0);
        press_key(4'hB, 1'b0);
        press_key(4'hC, 1'b0);
        press_key(4'hD, 1'b0);
        press_key(4'hE, 1'b0);
        expect_display("overflow", 32'hC163_8561);

        found = 1'b0;
        for (int t = 0; t < 2 * FRAME && !found; t++) begin
            tick();
            if (dsp.an == 4'b1011) found = 1'b1;
        end
        check("wait_d2", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_an", {28'd0, dsp.an}, 32'h0000_000F);
        check("mid_rst_seg", {24'd0, dsp.sieteseg_a2g_dp}, 32'h0000_00FF);
        tick();
        rst_n = 1'b1;
        check_scan("mid_rst");

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        press_key(4'h6, 1'b0);
        expect_display("key_after_rst", 32'hFFFF_FF41);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIG, default 4, meaning the number of multiplexed digits (fixed at 4 for this release).
REQ-002 SHALL have parameter DRIVE_CYC, default 50000, meaning the number of clock cycles a digit is driven per scan slot.
REQ-003 SHALL have parameter GUARD_CYC, default 500, meaning the all-anodes-off cycles before each slot (anti-ghosting).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 key_valid  in  1  one-cycle pulse; key_code is to be shifted into the display.
REQ-007 key_code  in  4  hex nibble, 0x0-0xF.
REQ-008 key_dp  in  1  decimal point of the new digit, 1 = lit.
REQ-009 clear  in  1  level; empties all digit registers.
REQ-010 lz_blank  in  1  1 = suppress leading zeros.
REQ-011 an  out  4  digit anode enables, active-low, bit0 = rightmost digit.
REQ-012 sieteseg_a2g_dp  out  8  segments a..g,dp, active-low (0 = lit), MSB = a.

Function
REQ-013 Digit store SHALL be 4 entries of {valid, nibble, dp}; all entries invalid after reset or clear.
REQ-014 On key_valid, entries SHALL shift one place left (3<-2<-1<-0), entry 3 discarded, entry 0 loaded with {1, key_code, key_dp}, in one cycle.
REQ-015 clear and key_valid in the same cycle: clear SHALL win; the key is dropped.
REQ-016 Scan FSM SHALL have states GUARD and DRIVE; reset enters GUARD with scan index 0.
REQ-017 GUARD: an = 4'b1111 for GUARD_CYC cycles, then DRIVE.
REQ-018 DRIVE: exactly one an bit low (the scan index) for DRIVE_CYC cycles, then GUARD with index+1.
REQ-019 Scan index SHALL wrap 3 -> 0; a full frame SHALL be 4*(GUARD_CYC+DRIVE_CYC) cycles.
REQ-020 One shared hex-to-7-seg converter SHALL encode the nibble selected by the scan index; no per-digit converters.
REQ-021 dp SHALL be forced to bit0 = 0 when the entry's dp = 1, otherwise 1.
REQ-022 An invalid entry SHALL drive sieteseg_a2g_dp = 8'hFF.
REQ-023 With lz_blank = 1, a valid zero entry with no valid non-zero entry to its left and dp = 0 SHALL output 8'hFF; entry 0 SHALL never be blanked by this rule.
REQ-024 an and sieteseg_a2g_dp SHALL be registered; segment data SHALL change only at the GUARD entry, never during DRIVE.
REQ-025 A store update during DRIVE of that digit SHALL appear at the next slot of that digit (latency at most one frame).
REQ-026 Counter width SHALL be ceil(log2(max(DRIVE_CYC,GUARD_CYC))) bits; GUARD_CYC = 0 SHALL skip GUARD (DRIVE -> DRIVE).

Reset
REQ-027 On rst_n low: an = 4'b1111, sieteseg_a2g_dp = 8'hFF, store invalid, FSM = GUARD, index 0, counter 0.
REQ-028 Reset mid-frame SHALL blank outputs immediately (asynchronous) and restart the frame at digit 0 after release.
REQ-029 key_valid in the first cycle after rst_n release SHALL be accepted.

Structure
REQ-030 A shared package SHALL hold the scan-state enum, the digit-entry record type, and the blank pattern constant 8'hFF.
REQ-031 The existing hex-to-7-seg converter SHALL be instantiated once as the sole sub-module; no other sub-modules.

Verification (DRIVE_CYC = 4, GUARD_CYC = 1)
REQ-032 Reset, no keys -> an cycles 1111,1110,1111,1101,1111,1011,1111,0111 with 1/4/1/4... cycle widths; seg always 8'hFF.
REQ-033 Keys 1,2,3,4 -> digit3..0 show 8'h9F, 8'h25, 8'h0D, 8'h99 in their slots.
REQ-034 Keys 0,0,5, lz_blank = 1 -> digits 3,2,1 = 8'hFF, digit0 = 8'h49; with lz_blank = 0 -> digits 2,1 = 8'h03.
REQ-035 key 8 with key_dp = 1 -> slot 0 shows 8'h00; clear and key_valid in the same cycle -> all slots 8'hFF.
REQ-036 Five keys A,B,C,D,E -> A discarded; digits show 8'h C1, 8'h63, 8'h85, 8'h61 (B..E).
REQ-037 rst_n pulsed low during DRIVE of digit 2 -> outputs 1111/FF the same cycle; after release the scan restarts at digit 0 with an empty store.
